iir_out_checker: RTL and testbench
==================================

Name: iir_out_checker

Overview:
- Self-checking capture block at the output end of the 4-stage opti_sos cascade; the counterpart of the stimulus driver that feeds the cascade.
- Consumes the valid-qualified 24-bit output stream and compares each sample against a golden vector preloaded into internal RAM, using an absolute tolerance.
- Reports pass/fail, error statistics, pipeline latency and stall timeout.
- Synthesizable, so it serves both the simulation bench and on-FPGA self-test.

Parameters:
- DW, 24, sample width (signed two's complement).
- N, 2048, samples per run.
- AW, 11, golden RAM address width; 2^AW >= N.
- TOL, 4, maximum permitted |dut - exp|; an error equal to TOL passes.
- TIMEOUT, 65535, idle cycles without dut_valid before the run is aborted.
- ERR_W, 16, width of the error/statistics counters (saturating).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  single-cycle pulse that arms a run.
- exp_wr_en  in  1  golden RAM write strobe.
- exp_wr_addr  in  AW  golden RAM write address.
- exp_wr_data  in  DW  golden sample.
- in_valid  in  1  cascade input valid, used only to measure latency.
- dut_valid  in  1  cascade output valid.
- dut_data  in  DW  cascade output sample.
- busy  out  1  high in ARMED or RUN.
- done  out  1  run finished, held until next start.
- pass  out  1  meaningful when done=1.
- timeout  out  1  run aborted by stall.
- overrun  out  1  dut_valid seen in DONE.
- sample_cnt  out  AW+1  samples compared.
- err_cnt  out  ERR_W  samples outside tolerance.
- first_err_idx  out  AW  index of first failing sample; 0 if none.
- max_abs_err  out  ERR_W  largest |error| seen, saturating.
- latency  out  ERR_W  cycles from first in_valid to first dut_valid.

Behaviour:

Reset:
- All outputs are 0 and the FSM is in IDLE.
- The RAM contents are not reset.
- Asserting rst_n low mid-run aborts the run immediately and discards all statistics.

FSM states: IDLE, ARMED, RUN, DONE.
- IDLE -> ARMED on start. All statistics and flags clear on that edge.
- ARMED -> RUN on the first dut_valid.
- RUN -> DONE when the Nth compare completes, or on timeout.
- DONE -> ARMED on start, which clears statistics. Re-arming from DONE is the only restart path.
- start in ARMED or RUN is ignored.

Golden RAM:
- Depth 2^AW, synchronous write.
- Writes are accepted only in IDLE or DONE. Writes in ARMED or RUN are dropped.

Compare pipeline (2 stages; gaps between dut_valid pulses are allowed):
- Stage 1, edge where dut_valid=1:
  - register dut_data;
  - issue the RAM read at index idx;
  - idx++.
- Stage 2, following edge:
  - diff = dut - exp, computed sign-extended to DW+1 bits, so no wrap;
  - absolute value is taken of the DW+1-bit diff;
  - if |diff| > TOL: err_cnt++ (saturating), and if this is the first error, first_err_idx <= index;
  - max_abs_err <= max(max_abs_err, min(|diff|, 2^ERR_W-1));
  - sample_cnt++.
- done, pass and the move to DONE take effect on the same edge as the Nth stage-2 update, i.e. 1 cycle after the Nth dut_valid is sampled.
- pass = (err_cnt==0) && !timeout.

Latency:
- Counter starts at the first in_valid sampled in ARMED; later in_valid pulses are ignored.
- It stops when the first dut_valid is sampled.
- latency = t_dut - t_in in cycles, saturating.
- If dut_valid arrives before any in_valid, latency = 0.

Timeout:
- Idle counter runs in ARMED (after the first in_valid) and in RUN. It resets on each dut_valid.
- When it reaches TIMEOUT: timeout=1, done=1, pass=0, go to DONE. sample_cnt keeps the count reached.

Other boundary conditions:
- dut_valid in DONE sets overrun=1 (sticky until start). Its data is not compared.
- dut_valid in IDLE is ignored.
- A start and a dut_valid on the same edge in DONE: the start wins, and that sample is not counted.

Test Plan:
1. Load exp[i]=i-1024 for i=0..2047; drive the identical stream with valid high contiguously -> done 1 cycle after the 2048th valid, pass=1, err_cnt=0, sample_cnt=2048, max_abs_err=0.
2. Same load; dut = exp+4 at idx 10, exp-5 at idx 20, exp+7 at idx 30 -> err_cnt=2, first_err_idx=20, max_abs_err=7, pass=0.
3. exp[0]=-8388608, dut[0]=+8388607 -> no wrap, |diff|=16777215, max_abs_err=65535 (saturated), err_cnt=1.
4. First in_valid at cycle 100, first dut_valid at cycle 124, random 0-3 cycle valid gaps thereafter -> latency=24, pass=1, sample_cnt=2048.
5. TIMEOUT=1000; stop dut_valid after 500 samples -> timeout=1 and done=1 exactly 1000 cycles after the last valid, sample_cnt=500, pass=0. Then drive 3 extra dut_valid -> overrun=1, counters unchanged.
6. Reset pulse mid-run at sample 700 -> all outputs 0; RAM writes during RUN are ignored; after start, a full clean run -> pass=1. A start issued in RUN has no effect.

Source files
------------

// File: rtl/iir_out_checker.sv
// Output-stream checker for the opti_sos cascade: compares each valid sample against a preloaded golden RAM within +/-TOL.
// Two-stage compare (result one cycle after dut_valid); no backpressure, the stream is absorbed as it arrives.
module iir_out_checker #(
    parameter int DW      = 24,
    parameter int N       = 2048,
    parameter int AW      = 11,
    parameter int TOL     = 4,
    parameter int TIMEOUT = 65535,
    parameter int ERR_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             exp_wr_en,
    input  logic [AW-1:0]    exp_wr_addr,
    input  logic [DW-1:0]    exp_wr_data,
    input  logic             in_valid,
    input  logic             dut_valid,
    input  logic [DW-1:0]    dut_data,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             timeout,
    output logic             overrun,
    output logic [AW:0]      sample_cnt,
    output logic [ERR_W-1:0] err_cnt,
    output logic [AW-1:0]    first_err_idx,
    output logic [ERR_W-1:0] max_abs_err,
    output logic [ERR_W-1:0] latency
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ARMED = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam int               TW        = $clog2(TIMEOUT + 1);
    localparam logic [AW:0]      N_L       = (AW+1)'(N);
    localparam logic [DW:0]      TOL_L     = (DW+1)'(TOL);
    localparam logic [TW-1:0]    IDLE_LAST = TW'(TIMEOUT - 1);
    localparam logic [ERR_W-1:0] ERR_MAX   = {ERR_W{1'b1}};

    logic [1:0]       state;
    logic [AW:0]      issue_cnt;
    logic             in_seen;
    logic [TW-1:0]    idle_cnt;
    logic             s2_vld;
    logic [AW-1:0]    s2_idx;
    logic [DW-1:0]    s2_dut;
    logic [DW-1:0]    exp_q;
    logic [DW-1:0]    mem [0:(1<<AW)-1];

    logic             armed_or_run;
    logic             issue;
    logic             idle_on;
    logic             tmo_hit;
    logic             last_cmp;
    logic             err_hit;
    logic [DW:0]      diff;
    logic [DW:0]      abs_diff;
    logic [ERR_W-1:0] clip_err;
    logic [ERR_W-1:0] err_nxt;
    logic [ERR_W-1:0] lat_inc;

    assign armed_or_run = (state == S_ARMED) || (state == S_RUN);
    assign busy         = armed_or_run;
    // Samples past N while still in RUN are not compared; they count as overrun.
    assign issue        = armed_or_run && dut_valid && (issue_cnt < N_L);
    assign idle_on      = (state == S_RUN) || ((state == S_ARMED) && in_seen);
    assign tmo_hit      = idle_on && !dut_valid && (idle_cnt == IDLE_LAST);
    assign lat_inc      = (latency == ERR_MAX) ? latency : latency + 1'b1;

    always_comb begin
        diff     = {s2_dut[DW-1], s2_dut} - {exp_q[DW-1], exp_q};
        abs_diff = diff[DW] ? (~diff + 1'b1) : diff;
        err_hit  = s2_vld && (abs_diff > TOL_L);
        clip_err = (abs_diff > (DW+1)'(ERR_MAX)) ? ERR_MAX : abs_diff[ERR_W-1:0];
        err_nxt  = (err_hit && (err_cnt != ERR_MAX)) ? err_cnt + 1'b1 : err_cnt;
        last_cmp = s2_vld && (sample_cnt == N_L - 1'b1);
    end

    always_ff @(posedge clk) begin
        if (exp_wr_en && ((state == S_IDLE) || (state == S_DONE)))
            mem[exp_wr_addr] <= exp_wr_data;
        if (issue) begin
            exp_q  <= mem[issue_cnt[AW-1:0]];
            s2_dut <= dut_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            issue_cnt     <= '0;
            in_seen       <= 1'b0;
            idle_cnt      <= '0;
            s2_vld        <= 1'b0;
            s2_idx        <= '0;
            done          <= 1'b0;
            pass          <= 1'b0;
            timeout       <= 1'b0;
            overrun       <= 1'b0;
            sample_cnt    <= '0;
            err_cnt       <= '0;
            first_err_idx <= '0;
            max_abs_err   <= '0;
            latency       <= '0;
        end else if (start && ((state == S_IDLE) || (state == S_DONE))) begin
            // Start wins over a same-edge dut_valid; that sample is dropped.
            state         <= S_ARMED;
            issue_cnt     <= '0;
            in_seen       <= 1'b0;
            idle_cnt      <= '0;
            s2_vld        <= 1'b0;
            done          <= 1'b0;
            pass          <= 1'b0;
            timeout       <= 1'b0;
            overrun       <= 1'b0;
            sample_cnt    <= '0;
            err_cnt       <= '0;
            first_err_idx <= '0;
            max_abs_err   <= '0;
            latency       <= '0;
        end else begin
            s2_vld <= issue;
            if (issue) begin
                issue_cnt <= issue_cnt + 1'b1;
                s2_idx    <= issue_cnt[AW-1:0];
            end

            if (state == S_ARMED) begin
                if (in_seen)
                    latency <= lat_inc;
                else if (in_valid)
                    in_seen <= 1'b1;
                if (dut_valid)
                    state <= S_RUN;
            end

            if (dut_valid)
                idle_cnt <= '0;
            else if (idle_on)
                idle_cnt <= idle_cnt + 1'b1;

            if (s2_vld) begin
                err_cnt    <= err_nxt;
                sample_cnt <= sample_cnt + 1'b1;
                if (err_hit && (err_cnt == '0))
                    first_err_idx <= s2_idx;
                if (clip_err > max_abs_err)
                    max_abs_err <= clip_err;
                if (last_cmp) begin
                    state <= S_DONE;
                    done  <= 1'b1;
                    pass  <= (err_nxt == '0);
                end
            end

            if (tmo_hit) begin
                state   <= S_DONE;
                done    <= 1'b1;
                timeout <= 1'b1;
                pass    <= 1'b0;
            end

            if (dut_valid && ((state == S_DONE) || ((state == S_RUN) && (issue_cnt == N_L))))
                overrun <= 1'b1;
        end
    end

endmodule

// File: tb/tb_iir_out_checker.sv
// Bench for iir_out_checker: table-driven error-injection runs, randomized runs against an arithmetic model,
// plus hand-written timeout / overrun / restart / mid-run reset sequences.
module tb_iir_out_checker;

    localparam int DW    = 24;
    localparam int N     = 2048;
    localparam int AW    = 11;
    localparam int TOL   = 4;
    localparam int TMO   = 1000;
    localparam int ERR_W = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic             exp_wr_en;
    logic [AW-1:0]    exp_wr_addr;
    logic [DW-1:0]    exp_wr_data;
    logic             in_valid;
    logic             dut_valid;
    logic [DW-1:0]    dut_data;
    logic             busy, done, pass, timeout, overrun;
    logic [AW:0]      sample_cnt;
    logic [ERR_W-1:0] err_cnt;
    logic [AW-1:0]    first_err_idx;
    logic [ERR_W-1:0] max_abs_err;
    logic [ERR_W-1:0] latency;

    iir_out_checker #(
        .DW(DW), .N(N), .AW(AW), .TOL(TOL), .TIMEOUT(TMO), .ERR_W(ERR_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .exp_wr_en(exp_wr_en), .exp_wr_addr(exp_wr_addr), .exp_wr_data(exp_wr_data),
        .in_valid(in_valid), .dut_valid(dut_valid), .dut_data(dut_data),
        .busy(busy), .done(done), .pass(pass), .timeout(timeout), .overrun(overrun),
        .sample_cnt(sample_cnt), .err_cnt(err_cnt), .first_err_idx(first_err_idx),
        .max_abs_err(max_abs_err), .latency(latency)
    );

    always #5 clk = ~clk;

    typedef struct {
        string name;
        int    lat;
        int    ia, da, ib, db, ic, dc;
        bit    wrap0;
        int    e_err, e_first, e_max;
        bit    e_pass;
    } vec_t;

    int   checks = 0;
    int   errors = 0;
    int   ev[N];
    int   dq[N];
    vec_t vt[6];

    task automatic chk(input string name, input longint act, input longint expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    task automatic ram_wr(input int a, input int d);
        exp_wr_en   = 1'b1;
        exp_wr_addr = a[AW-1:0];
        exp_wr_data = d[DW-1:0];
        @(negedge clk);
        exp_wr_en   = 1'b0;
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, " busy"}, busy, 0);
        chk({name, " done"}, done, 0);
        chk({name, " pass"}, pass, 0);
        chk({name, " timeout"}, timeout, 0);
        chk({name, " overrun"}, overrun, 0);
        chk({name, " sample_cnt"}, sample_cnt, 0);
        chk({name, " err_cnt"}, err_cnt, 0);
        chk({name, " first_err_idx"}, first_err_idx, 0);
        chk({name, " max_abs_err"}, max_abs_err, 0);
        chk({name, " latency"}, latency, 0);
    endtask

    // lat >= 0: in_valid leads the first dut_valid by lat cycles; lat < 0: in_valid only arrives mid-run.
    task automatic drive_run(input int lat, input int max_gap, input string name);
        int g;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (lat >= 0) begin
            in_valid = 1'b1;
            if (lat > 0) begin
                @(negedge clk);
                in_valid = 1'b0;
                repeat (lat - 1) @(negedge clk);
            end
        end
        for (int i = 0; i < N; i++) begin
            dut_valid = 1'b1;
            dut_data  = dq[i][DW-1:0];
            if (lat < 0 && i == 5) in_valid = 1'b1;
            @(negedge clk);
            in_valid = 1'b0;
            if (max_gap > 0 && i < N - 1) begin
                dut_valid = 1'b0;
                g = int'($urandom_range(max_gap, 0));
                repeat (g) @(negedge clk);
            end
        end
        dut_valid = 1'b0;
        chk({name, " done_early"}, done, 0);
        @(negedge clk);
        chk({name, " done"}, done, 1);
    endtask

    task automatic check_results(input string name, input int e_err, input int e_first,
                                 input int e_max, input bit e_pass, input int e_lat);
        chk({name, " sample_cnt"}, sample_cnt, N);
        chk({name, " err_cnt"}, err_cnt, e_err);
        chk({name, " first_err_idx"}, first_err_idx, e_first);
        chk({name, " max_abs_err"}, max_abs_err, e_max);
        chk({name, " pass"}, pass, e_pass);
        chk({name, " latency"}, latency, e_lat);
        chk({name, " timeout"}, timeout, 0);
        chk({name, " overrun"}, overrun, 0);
        chk({name, " busy"}, busy, 0);
    endtask

    task automatic model(output int e_err, output int e_first, output int e_max, output bit e_pass);
        longint d;
        e_err = 0; e_first = 0; e_max = 0;
        for (int i = 0; i < N; i++) begin
            d = longint'(dq[i]) - longint'(ev[i]);
            if (d < 0) d = -d;
            if (d > TOL) begin
                if (e_err == 0) e_first = i;
                e_err++;
            end
            if (d > e_max) e_max = (d > 65535) ? 65535 : int'(d);
        end
        e_pass = (e_err == 0);
    endtask

    initial begin
        int m_err, m_first, m_max, lat;
        bit m_pass;

        vt[0] = '{"clean",    4, -1, 0, -1, 0, -1, 0, 1'b0, 0, 0, 0, 1'b1};
        vt[1] = '{"tol",      0, 10, 4, 20, -5, 30, 7, 1'b0, 2, 20, 7, 1'b0};
        vt[2] = '{"wrap",    24, -1, 0, -1, 0, -1, 0, 1'b1, 1, 0, 65535, 1'b0};
        vt[3] = '{"edge_tol",-1,  0, -4, 2047, 4, -1, 0, 1'b0, 0, 0, 4, 1'b1};
        vt[4] = '{"first0",   7, 2047, -6, 0, 5, -1, 0, 1'b0, 2, 0, 6, 1'b0};
        vt[5] = '{"sat",      1, 1000, 100000, 5, -3, -1, 0, 1'b0, 1, 1000, 65535, 1'b0};

        rst_n = 1'b0; start = 1'b0; exp_wr_en = 1'b0; exp_wr_addr = '0; exp_wr_data = '0;
        in_valid = 1'b0; dut_valid = 1'b0; dut_data = '0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // dut_valid while idle must not start anything
        dut_valid = 1'b1;
        repeat (2) @(negedge clk);
        dut_valid = 1'b0;
        chk("idle_valid busy", busy, 0);
        chk("idle_valid sample_cnt", sample_cnt, 0);
        chk("idle_valid overrun", overrun, 0);

        for (int i = 0; i < N; i++) begin
            ev[i] = i - 1024;
            ram_wr(i, ev[i]);
        end

        foreach (vt[k]) begin
            for (int i = 0; i < N; i++) dq[i] = ev[i];
            if (vt[k].wrap0) begin
                ram_wr(0, -8388608);
                dq[0] = 8388607;
            end
            if (vt[k].ia >= 0) dq[vt[k].ia] += vt[k].da;
            if (vt[k].ib >= 0) dq[vt[k].ib] += vt[k].db;
            if (vt[k].ic >= 0) dq[vt[k].ic] += vt[k].dc;
            drive_run(vt[k].lat, 0, vt[k].name);
            check_results(vt[k].name, vt[k].e_err, vt[k].e_first, vt[k].e_max, vt[k].e_pass,
                          (vt[k].lat < 0) ? 0 : vt[k].lat);
            if (vt[k].wrap0) ram_wr(0, ev[0]);
        end

        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < N; i++) begin
                dq[i] = ev[i];
                if (r == 1 && $urandom_range(8) == 0) dq[i] += int'($urandom_range(12)) - 6;
            end
            if (r == 1) dq[$urandom_range(N - 1)] += 70000;
            lat = (r == 0) ? 24 : int'($urandom_range(40, 1));
            model(m_err, m_first, m_max, m_pass);
            drive_run(lat, 3, (r == 0) ? "rand_clean" : "rand_err");
            check_results((r == 0) ? "rand_clean" : "rand_err", m_err, m_first, m_max, m_pass, lat);
        end

        // Stall after 500 samples: timeout exactly TMO cycles after the last valid
        for (int i = 0; i < N; i++) dq[i] = ev[i];
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 500; i++) begin
            dut_valid = 1'b1;
            dut_data  = dq[i][DW-1:0];
            @(negedge clk);
        end
        dut_valid = 1'b0;
        repeat (TMO - 1) @(negedge clk);
        chk("tmo early timeout", timeout, 0);
        chk("tmo early done", done, 0);
        @(negedge clk);
        chk("tmo timeout", timeout, 1);
        chk("tmo done", done, 1);
        chk("tmo pass", pass, 0);
        chk("tmo sample_cnt", sample_cnt, 500);
        chk("tmo busy", busy, 0);
        chk("tmo latency", latency, 1);

        dut_valid = 1'b1;
        dut_data  = 24'h000005;
        repeat (3) @(negedge clk);
        dut_valid = 1'b0;
        @(negedge clk);
        chk("overrun flag", overrun, 1);
        chk("overrun sample_cnt", sample_cnt, 500);
        chk("overrun err_cnt", err_cnt, 0);
        chk("overrun done", done, 1);

        // start and dut_valid on the same edge in DONE: start wins, sample dropped
        start = 1'b1;
        dut_valid = 1'b1;
        dut_data = '0;
        @(negedge clk);
        start = 1'b0;
        dut_valid = 1'b0;
        chk("restart busy", busy, 1);
        chk("restart sample_cnt", sample_cnt, 0);
        chk("restart overrun", overrun, 0);
        chk("restart timeout", timeout, 0);
        chk("restart done", done, 0);
        drive_run(3, 0, "after_restart");
        check_results("after_restart", 0, 0, 0, 1'b1, 3);

        // Mid-run: ignored start and RAM write, then reset at sample 700
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 700; i++) begin
            dut_valid = 1'b1;
            dut_data  = dq[i][DW-1:0];
            if (i == 400) begin
                start       = 1'b1;
                exp_wr_en   = 1'b1;
                exp_wr_addr = 11'd5;
                exp_wr_data = 24'd777;
            end
            @(negedge clk);
            start     = 1'b0;
            exp_wr_en = 1'b0;
        end
        dut_valid = 1'b0;
        @(negedge clk);
        chk("midrun sample_cnt", sample_cnt, 700);
        chk("midrun busy", busy, 1);
        chk("midrun latency", latency, 1);
        rst_n = 1'b0;
        #1;
        chk_all_zero("midrun_reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        drive_run(2, 1, "post_reset");
        check_results("post_reset", 0, 0, 0, 1'b1, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
